// File: rtl/puf_response_collector_if.sv
// Request, arbiter and result signals of the PUF response collector.
// The master side issues requests and models the race arbiter; the slave side is the collector.
interface puf_response_collector_if #(
    parameter int RESP_BITS = 16
) ();
    logic                 start;
    logic [15:0]          seed;
    logic [15:0]          challenge;
    logic                 arb_reset;
    logic                 race_start;
    logic                 arb_done;
    logic                 arb_out;
    logic [RESP_BITS-1:0] response;
    logic                 valid;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        output start, seed, arb_done, arb_out,
        input  challenge, arb_reset, race_start, response, valid, busy, timeout_err
    );

    modport slave (
        input  start, seed, arb_done, arb_out,
        output challenge, arb_reset, race_start, response, valid, busy, timeout_err
    );
endinterface

// File: rtl/puf_response_collector.sv
// Runs RESP_BITS arbiter races per request, stepping a 16-bit LFSR challenge between races.
// Per bit: RST_CYCLES + 1 + wait + 1 cycles; start is ignored while busy, valid is a one-cycle pulse.
module puf_response_collector #(
    parameter int RESP_BITS  = 16,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    puf_response_collector_if.slave  io_bus
);
    localparam int CW  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB_RST,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_FINISH
    } state_t;

    state_t               r_state;
    logic [15:0]          r_challenge;
    logic [RESP_BITS-1:0] r_response;
    logic [CW-1:0]        r_bit_cnt;
    logic [RCW-1:0]       r_rst_cnt;
    logic [TW-1:0]        r_to_cnt;
    logic                 r_bit;
    logic                 r_arb_reset;
    logic                 r_race_start;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_timeout_err;
    logic                 r_done_meta;
    logic                 r_done_s;
    logic                 r_out_meta;
    logic                 r_out_s;

    logic                 w_lfsr_fb;
    logic [15:0]          w_lfsr_next;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
    assign w_lfsr_fb   = r_challenge[15] ^ r_challenge[13] ^ r_challenge[12] ^ r_challenge[10];
    assign w_lfsr_next = {r_challenge[14:0], w_lfsr_fb};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_challenge   <= '0;
            r_response    <= '0;
            r_bit_cnt     <= '0;
            r_rst_cnt     <= '0;
            r_to_cnt      <= '0;
            r_bit         <= 1'b0;
            r_arb_reset   <= 1'b1;
            r_race_start  <= 1'b0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_done_meta   <= 1'b0;
            r_done_s      <= 1'b0;
            r_out_meta    <= 1'b0;
            r_out_s       <= 1'b0;
        end else begin
            r_done_meta  <= io_bus.arb_done;
            r_done_s     <= r_done_meta;
            r_out_meta   <= io_bus.arb_out;
            r_out_s      <= r_out_meta;
            r_race_start <= 1'b0;
            r_valid      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        // A zero seed would lock the LFSR at zero forever.
                        r_challenge   <= (io_bus.seed == 16'h0000) ? 16'h0001 : io_bus.seed;
                        r_response    <= '0;
                        r_bit_cnt     <= '0;
                        r_timeout_err <= 1'b0;
                        r_rst_cnt     <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= S_ARB_RST;
                    end
                end
                S_ARB_RST: begin
                    if (r_rst_cnt == RCW'(RST_CYCLES - 1)) begin
                        r_arb_reset  <= 1'b0;
                        r_race_start <= 1'b1;
                        r_state      <= S_LAUNCH;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                S_LAUNCH: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    // done is checked first so it wins a tie with the final timeout cycle.
                    if (r_done_s) begin
                        r_bit   <= r_out_s;
                        r_state <= S_CAPTURE;
                    end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
                        r_bit         <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_CAPTURE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_response[r_bit_cnt] <= r_bit;
                    r_challenge           <= w_lfsr_next;
                    r_arb_reset           <= 1'b1;
                    r_rst_cnt             <= '0;
                    if (r_bit_cnt == CW'(RESP_BITS - 1)) begin
                        r_valid <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_state   <= S_ARB_RST;
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.challenge   = r_challenge;
    assign io_bus.arb_reset   = r_arb_reset;
    assign io_bus.race_start  = r_race_start;
    assign io_bus.response    = r_response;
    assign io_bus.valid       = r_valid;
    assign io_bus.busy        = r_busy;
    assign io_bus.timeout_err = r_timeout_err;
endmodule

// File: doc/puf_response_collector.md
PUF_RESPONSE_COLLECTOR -- requirements
Module: puf_response_collector

Interface
REQ-001 Parameter RESP_BITS, default 16: number of response bits collected per request.
REQ-002 Parameter RST_CYCLES, default 4: number of cycles arb_reset is held high before each race.
REQ-003 Parameter TIMEOUT, default 255: number of WAIT cycles allowed before a race is declared lost.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 start  input  1: request pulse; sampled only in IDLE.
REQ-007 seed  input  16: initial challenge, captured on an accepted start.
REQ-008 challenge  output  16: challenge vector driven to the delay-line stages.
REQ-009 arb_reset  output  1: reset to the race arbiter.
REQ-010 race_start  output  1: one-cycle launch pulse into both delay lines.
REQ-011 arb_done  input  1: asynchronous done flag from the race arbiter.
REQ-012 arb_out  input  1: asynchronous winner bit from the race arbiter.
REQ-013 response  output  RESP_BITS: collected response, LSB = first race.
REQ-014 valid  output  1: one-cycle pulse when response is complete.
REQ-015 busy  output  1: high in every state except IDLE.
REQ-016 timeout_err  output  1: sticky flag; high if any race in the current request timed out.

Function
REQ-017 arb_done and arb_out SHALL each pass through a two-flop synchronizer; all decisions use the synchronized copies (done_s, out_s).
REQ-018 FSM states SHALL be: IDLE, ARB_RST, LAUNCH, WAIT, CAPTURE, FINISH.
REQ-019 IDLE with start=1 SHALL do the following: load challenge<=seed, clear response, clear bit_cnt, clear timeout_err, then go to ARB_RST. A start outside IDLE SHALL be ignored.
REQ-020 ARB_RST SHALL drive arb_reset=1 for exactly RST_CYCLES cycles, then go to LAUNCH.
REQ-021 LAUNCH SHALL drive race_start=1 for exactly one cycle with arb_reset=0, clear the timeout counter, and go to WAIT.
REQ-022 WAIT with done_s=1 SHALL go to CAPTURE with the captured bit = out_s.
REQ-023 WAIT with done_s=0 for TIMEOUT consecutive cycles SHALL go to CAPTURE with the captured bit = 0 and set timeout_err=1.
REQ-024 If done_s=1 occurs in the same cycle the counter reaches TIMEOUT, done SHALL take priority: no error, and the captured bit = out_s.
REQ-025 CAPTURE SHALL write the captured bit into response[bit_cnt] and advance challenge one LFSR step: Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0.
REQ-026 After CAPTURE: if bit_cnt==RESP_BITS-1, go to FINISH; otherwise increment bit_cnt and go to ARB_RST.
REQ-027 FINISH SHALL pulse valid=1 for one cycle and return to IDLE. response and timeout_err SHALL hold until the next accepted start.
REQ-028 An all-zero seed SHALL be replaced by 16'h0001 on load so the LFSR cannot lock up.
REQ-029 challenge SHALL be stable from LAUNCH until CAPTURE.
REQ-030 Per-bit latency SHALL be RST_CYCLES + 1 (LAUNCH) + WAIT cycles + 1 (CAPTURE), where WAIT cycles include the 2-cycle synchronizer delay.

Reset
REQ-031 Reset SHALL force FSM=IDLE and set: challenge=0, response=0, bit_cnt=0, timeout counter=0, synchronizers=0, arb_reset=1, race_start=0, valid=0, busy=0, timeout_err=0.
REQ-032 Reset asserted mid-request SHALL abort the request with no valid pulse. The next start after reset SHALL begin a full new request.
REQ-033 arb_reset SHALL stay 1 in IDLE so the arbiter is held cleared between requests.

Verification
REQ-034 Arbiter model returns done 10 cycles after race_start with out = challenge[0], seed=16'hACE1 -> valid after 16 races; response matches the reference-model LFSR bit sequence; timeout_err=0.
REQ-035 Arbiter never asserts done, TIMEOUT=255 -> each bit times out; response=16'h0000, timeout_err=1, valid pulses once.
REQ-036 start pulsed again while busy=1 -> ignored; challenge sequence and response unchanged.
REQ-037 Reset asserted during WAIT of bit 5 -> busy=0, valid never pulses, response=0. A fresh start then completes normally.
REQ-038 seed=16'h0000 -> first challenge 16'h0001; LFSR never reaches 0 across all 16 races.
REQ-039 done arriving exactly at timeout count 255 -> bit = out_s, timeout_err stays 0.
